// File: rtl/jtag_ir_dr.sv
// jtag_ir_dr: JTAG instruction register plus IDCODE/BYPASS/USER data registers driven by the TAP state
module jtag_ir_dr #(
  parameter int IR_WIDTH = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_563D,
  parameter int USER_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(4'h1),
  parameter logic [IR_WIDTH-1:0] OP_USER = IR_WIDTH'(4'h8)
) (
  input  logic tck,
  input  logic trst,
  input  logic [4:0] tap_state,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  output logic [IR_WIDTH-1:0] ir,
  output logic [USER_WIDTH-1:0] user_data,
  output logic user_update
);
  localparam logic [4:0] st_tlr = 5'h00, st_cap_dr = 5'h04, st_cap_ir = 5'h05, st_shift_dr = 5'h06,
    st_shift_ir = 5'h07, st_upd_dr = 5'h14, st_upd_ir = 5'h15;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0] id_shift;
  logic bypass;
  logic [USER_WIDTH-1:0] user_shift;
  logic sel_id, sel_user;
  assign sel_id = ir == OP_IDCODE;
  assign sel_user = ir == OP_USER;
  always_ff @(posedge tck)
    if (trst) begin
      ir <= OP_IDCODE;
      ir_shift <= '0;
      id_shift <= '0;
      bypass <= 1'b0;
      user_shift <= '0;
      user_data <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      case (tap_state)
        st_tlr: ir <= OP_IDCODE;
        st_cap_ir: ir_shift <= IR_WIDTH'(2'b01);
        st_shift_ir: ir_shift <= IR_WIDTH'({tdi, ir_shift} >> 1);
        st_upd_ir: ir <= ir_shift;
        st_cap_dr:
          if (sel_id) id_shift <= IDCODE_VALUE;
          else if (sel_user) user_shift <= user_data;
          else bypass <= 1'b0;
        st_shift_dr:
          if (sel_id) id_shift <= {tdi, id_shift[31:1]};
          else if (sel_user) user_shift <= USER_WIDTH'({tdi, user_shift} >> 1);
          else bypass <= tdi;
        st_upd_dr:
          if (sel_user) begin
            user_data <= user_shift;
            user_update <= 1'b1;
          end
        default: ;
      endcase
    end
  always_comb begin
    tdo_en = tap_state == st_shift_ir || tap_state == st_shift_dr;
    tdo = tap_state == st_shift_ir ? ir_shift[0] :
          tap_state == st_shift_dr ? (sel_id ? id_shift[0] : sel_user ? user_shift[0] : bypass) : 1'b0;
  end
endmodule

// File: tb/tb_jtag_ir_dr.sv
// tb_jtag_ir_dr: directed scans checked every cycle against an arithmetic model plus literal expectations
module tb_jtag_ir_dr;
  logic tck = 0, trst = 1, tdi = 0, tdo, tdo_en, user_update;
  logic [4:0] tap_state = 5'h00;
  logic [3:0] ir;
  logic [7:0] user_data;
  int total = 0, bad = 0, upd_cnt = 0;
  bit chk_en = 0;
  logic last_tdo;
  longint m_ir, m_irs, m_id, m_byp, m_us, m_ud, m_upd;
  jtag_ir_dr dut (.tck(tck), .trst(trst), .tap_state(tap_state), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .ir(ir), .user_data(user_data), .user_update(user_update));
  always #5 tck = ~tck;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic longint exp_tdo();
    longint dr_bit;
    dr_bit = m_ir == 1 ? m_id % 2 : m_ir == 8 ? m_us % 2 : m_byp;
    return tap_state == 5'h07 ? m_irs % 2 : tap_state == 5'h06 ? dr_bit : 0;
  endfunction
  task automatic model_update(input logic [4:0] s, input logic d, input logic r);
    if (r) begin
      m_ir = 1; m_irs = 0; m_id = 0; m_byp = 0; m_us = 0; m_ud = 0; m_upd = 0;
    end else begin
      m_upd = 0;
      case (s)
        5'h00: m_ir = 1;
        5'h05: m_irs = 1;
        5'h07: m_irs = m_irs / 2 + d * 8;
        5'h15: m_ir = m_irs;
        5'h04:
          if (m_ir == 1) m_id = 64'h1000_563D;
          else if (m_ir == 8) m_us = m_ud;
          else m_byp = 0;
        5'h06:
          if (m_ir == 1) m_id = m_id / 2 + d * 64'd2147483648;
          else if (m_ir == 8) m_us = m_us / 2 + d * 128;
          else m_byp = d;
        5'h14:
          if (m_ir == 8) begin
            m_ud = m_us;
            m_upd = 1;
          end
        default: ;
      endcase
    end
  endtask
  always @(negedge tck)
    if (chk_en) begin
      chk("tdo", tdo, exp_tdo());
      chk("tdo_en", tdo_en, tap_state == 5'h06 || tap_state == 5'h07);
      chk("ir", ir, m_ir);
      chk("user_data", user_data, m_ud);
      chk("user_update", user_update, m_upd);
    end
  task automatic step(input logic [4:0] s, input logic d = 0, input logic r = 0);
    tap_state = s;
    tdi = d;
    trst = r;
    #2;
    last_tdo = tdo;
    if (user_update === 1'b1) upd_cnt++;
    @(posedge tck);
    #1;
    model_update(s, d, r);
  endtask
  task automatic scan_ir(input logic [3:0] v, output logic [3:0] got);
    step(5'h02); step(5'h03); step(5'h05);
    for (int i = 0; i < 4; i++) begin
      step(5'h07, v[i]);
      got[i] = last_tdo;
    end
    step(5'h09); step(5'h15); step(5'h01);
  endtask
  task automatic scan_dr(input logic [31:0] v, input int n, output logic [31:0] got);
    got = '0;
    step(5'h02); step(5'h04);
    for (int i = 0; i < n; i++) begin
      step(5'h06, v[i]);
      got[i] = last_tdo;
    end
    step(5'h08); step(5'h14); step(5'h01);
  endtask
  initial begin
    logic [3:0] g4;
    logic [31:0] g32;
    logic [7:0] v8;
    int u0;
    step(5'h00, 0, 1);
    chk_en = 1;
    upd_cnt = 0;
    chk("reset_ir", ir, 4'h1);
    chk("reset_user_data", user_data, 8'h00);
    chk("reset_user_update", user_update, 1'b0);
    step(5'h00); step(5'h01);
    scan_dr(32'h0, 32, g32);
    chk("idcode_stream", g32, 32'h1000_563D);
    chk("idcode_ir", ir, 4'h1);
    scan_ir(4'hF, g4);
    chk("ir_scan_tdo", g4, 4'b0001);
    chk("ir_after_update", ir, 4'hF);
    scan_dr(32'b1101, 4, g32);
    chk("bypass_ff_stream", g32[3:0], 4'b1010);
    scan_ir(4'h5, g4);
    chk("ir_5", ir, 4'h5);
    scan_dr(32'b1101, 4, g32);
    chk("bypass_unknown_stream", g32[3:0], 4'b1010);
    scan_ir(4'h8, g4);
    u0 = upd_cnt;
    scan_dr(32'hA5, 8, g32);
    chk("user_write", user_data, 8'hA5);
    chk("user_update_pulses", upd_cnt - u0, 1);
    scan_dr(32'h3C, 8, g32);
    chk("user_readback", g32[7:0], 8'hA5);
    chk("user_write2", user_data, 8'h3C);
    chk("user_update_pulses2", upd_cnt - u0, 2);
    v8 = 8'h5A;
    step(5'h02); step(5'h04);
    for (int i = 0; i < 4; i++) begin
      step(5'h06, v8[i]);
      g32[i] = last_tdo;
    end
    step(5'h08); step(5'h10); step(5'h10); step(5'h10); step(5'h12);
    for (int i = 4; i < 8; i++) begin
      step(5'h06, v8[i]);
      g32[i] = last_tdo;
    end
    step(5'h08); step(5'h14); step(5'h01);
    chk("pause_readback", g32[7:0], 8'h3C);
    chk("pause_write", user_data, 8'h5A);
    u0 = upd_cnt;
    step(5'h02); step(5'h04);
    step(5'h06, 1); step(5'h06, 1); step(5'h06, 1);
    step(5'h06, 1, 1);
    step(5'h01);
    chk("abort_user_data", user_data, 8'h00);
    chk("abort_no_strobe", upd_cnt - u0, 0);
    chk("abort_ir", ir, 4'h1);
    scan_ir(4'h8, g4);
    for (int i = 0; i < 5; i++) begin
      step(5'h0C, 1);
      chk("unused_tdo", last_tdo, 1'b0);
    end
    chk("unused_ir", ir, 4'h8);
    chk("unused_tdo_en", tdo_en, 1'b0);
    scan_dr(32'h0, 8, g32);
    chk("unused_user_hold", g32[7:0], 8'h00);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_ir_dr.md
# jtag_ir_dr

Instruction-register and data-register back end for the JTAG TAP. It sits directly downstream of the TAP state machine: it consumes the TAP's registered 5-bit state each `tck` and implements the IR scan chain and three data registers:

- IDCODE, 32-bit, read-only.
- BYPASS, 1-bit.
- USER, `USER_WIDTH`-bit, read/write.

It drives `tdo` back toward the pin. It also exposes the USER register, with an update strobe, to on-chip logic.

## Interface

Parameters:
- `IR_WIDTH`, 4: instruction register width, ≥2.
- `IDCODE_VALUE`, 32'h1000_563D: IDCODE contents; bit 0 must be 1.
- `USER_WIDTH`, 8: USER data register width, ≥1.
- `OP_IDCODE`, 4'h1: IDCODE opcode.
- `OP_USER`, 4'h8: USER opcode.
- BYPASS: all-ones opcode, fixed. Every unlisted opcode also selects BYPASS.

Ports (one clock; reset is synchronous and active-high):
- `tck` input 1: JTAG clock; all state updates on its rising edge.
- `trst` input 1: synchronous, active-high reset.
- `tap_state` input 5: current TAP state. Encoding:
  - 0x00 TestLogicReset, 0x01 RunTestOrIdle, 0x02 SelectDrScan, 0x03 SelectIrScan
  - 0x04 CaptureDr, 0x05 CaptureIr, 0x06 ShiftDr, 0x07 ShiftIr
  - 0x08 Exit1Dr, 0x09 Exit1Ir, 0x10 PauseDr, 0x11 PauseIr
  - 0x12 Exit2Dr, 0x13 Exit2Ir, 0x14 UpdateDr, 0x15 UpdateIr
- `tdi` input 1: serial scan data in.
- `tdo` output 1: serial scan data out.
- `tdo_en` output 1: high while `tap_state` is ShiftDr or ShiftIr.
- `ir` output IR_WIDTH: active instruction.
- `user_data` output USER_WIDTH: committed USER register.
- `user_update` output 1: one-cycle strobe when `user_data` is written.

## Operation

Registers: `ir`, `ir_shift[IR_WIDTH]`, `id_shift[32]`, `bypass`, `user_shift[USER_WIDTH]`, `user_data`, `user_update`.

Reset (`trst`=1 at a rising edge) has priority over everything. Values after reset:
- `ir` = OP_IDCODE.
- `ir_shift`, `id_shift`, `bypass`, `user_shift` = 0.
- `user_data` = 0, `user_update` = 0.

DR selection from `ir`: OP_IDCODE selects `id_shift`, OP_USER selects `user_shift`, any other value selects `bypass`.

Actions on a `tck` edge without reset, keyed on `tap_state` in that cycle:
- **TestLogicReset:** `ir` ← OP_IDCODE. Shift registers hold. `user_data` holds.
- **CaptureIr:** `ir_shift` ← {0…0, 2'b01}.
- **ShiftIr:** `ir_shift` ← {`tdi`, `ir_shift[IR_WIDTH-1:1]`}, LSB-first.
- **UpdateIr:** `ir` ← `ir_shift`.
- **CaptureDr:** loads only the selected DR.
  - IDCODE: `id_shift` ← IDCODE_VALUE.
  - USER: `user_shift` ← `user_data`.
  - BYPASS: `bypass` ← 0.
- **ShiftDr:** the selected DR shifts right with `tdi` entering the MSB; `bypass` ← `tdi`. Unselected DRs hold.
- **UpdateDr:** only when `ir`==OP_USER: `user_data` ← `user_shift` and `user_update` ← 1.
- **All other states, including unused encodings (0x0A–0x0F, 0x16–0x1F):** every register holds.
- `user_update` is 0 on every edge not covered by the UpdateDr rule.

Output `tdo`, combinational from registers and `tap_state`:
- ShiftIr: `ir_shift[0]`.
- ShiftDr: bit 0 of the selected DR (`bypass` for BYPASS).
- Otherwise: 0.

`tdo_en` is combinational: 1 exactly in ShiftIr and ShiftDr.

An IR scan leaves `ir` unchanged until UpdateIr, so a scan aborted through TestLogicReset leaves `ir` = OP_IDCODE. A DR scan aborted before UpdateDr leaves `user_data` unchanged and produces no `user_update`.

## Timing

- Capture-to-output: a register loaded in the Capture cycle presents bit 0 on `tdo` during the first Shift cycle.
- One bit shifts per ShiftDr/ShiftIr cycle. Pause and Exit states hold shift contents, so scans resume intact.
- `ir` changes on the edge that ends UpdateIr. The new instruction governs the next CaptureDr.
- `user_data` and `user_update` become visible in the cycle after UpdateDr. `user_update` is high for exactly one cycle; consecutive USER UpdateDr passes give one pulse each.
- `trst` mid-scan: the register values listed under Reset apply on the following cycle, and `tdo`=0 unless the new `tap_state` is a shift state.

## Test plan

- **Reset then IDCODE read:** `trst`, then TestLogicReset → RunTestOrIdle → SelectDrScan → CaptureDr → 32×ShiftDr. `tdo` stream LSB-first = 32'h1000_563D; `ir`=4'h1 throughout.
- **IR scan:** CaptureIr, 4×ShiftIr with `tdi`=1,1,1,1, Exit1Ir, UpdateIr. `tdo` during shift = 1,0,0,0; `ir`=4'hF after update.
- **BYPASS, and unknown opcode treated as BYPASS:** load `ir`=4'hF, then separately `ir`=4'h5. DR scan of `tdi`=1,0,1,1 yields `tdo`=0,1,0,1 in both cases (one-cycle delay, leading 0).
- **USER write/read:** `ir`=4'h8; DR scan shifting 8'hA5 LSB-first, UpdateDr. `user_data`=8'hA5 and `user_update` high for one cycle. A second DR scan returns 8'hA5 on `tdo`.
- **Pause/abort:** USER scan paused mid-shift (PauseDr ×3, Exit2Dr, ShiftDr) completes correctly. A scan aborted via `trst` before UpdateDr leaves `user_data`=0 with no strobe.
- **Unused `tap_state` 0x0C held for 5 cycles:** all registers unchanged, `tdo`=0, `tdo_en`=0.
